// File: rtl/ram_block_mover.sv
// ram_block_mover: COPY/FILL block jobs over a single-port synchronous RAM (1-cycle read latency).
// Registered address/we; COPY write data comes straight from the RAM output of the preceding READ.
module ram_block_mover #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    state_t                state_q, state_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  we_q, we_d;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: if (start) begin
                op_d    = op;
                src_d   = src_addr;
                dst_d   = dst_addr;
                rem_d   = length;
                fill_d  = fill_value;
                state_d = (length == '0) ? FINISH : op ? WRITE : READ;
            end
            READ: state_d = WRITE;
            WRITE: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == REM_ONE) ? FINISH : op_q ? WRITE : READ;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Address and we are registered, so they are derived from the state being entered
        addr_d = (state_d == READ) ? src_d : (state_d == WRITE) ? dst_d : addr_q;
        we_d   = (state_d == WRITE);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end
    assign busy      = (state_q == READ) || (state_q == WRITE);
    assign done      = (state_q == FINISH);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = op_q ? fill_q : mem_rdata;
endmodule

// File: tb/tb_ram_block_mover.sv
// tb_ram_block_mover: random and directed COPY/FILL jobs against a byte-array memory model.
module tb_ram_block_mover;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    logic          clk = 1'b0;
    logic          reset_n, start, op, busy, done, mem_we;
    logic [AW-1:0] src_addr, dst_addr, mem_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_value, mem_wdata, mem_rdata;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [N];
    logic [DW-1:0] ref_mem [N];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    // Synchronous single-port RAM; pre_we is a bench-only back door used while the mover is idle
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        mem_rdata <= ram[mem_addr];
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask
    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== ref_mem[i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask
    task automatic run_job(input string tag, input logic o, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input logic [AW:0] l,
                           input logic [DW-1:0] v, input int inj);
        int exp_done, budget;
        int done_cyc = 0, nbusy = 0, nwe = 0, ndone = 0;
        for (int i = 0; i < int'(l); i++)
            ref_mem[(int'(d) + i) % N] = o ? v : ref_mem[(int'(s) + i) % N];
        exp_done = (l == 0) ? 1 : o ? int'(l) + 1 : 2 * int'(l) + 1;
        budget   = exp_done + 4;
        @(negedge clk);
        start = 1'b1; op = o; src_addr = s; dst_addr = d; length = l; fill_value = v;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c == inj) begin
                start = 1'b1; op = ~o; src_addr = s + 12'd7; dst_addr = d + 12'd9;
                length = 13'd5; fill_value = ~v;
            end else if (c == inj + 1) start = 1'b0;
            if (busy) nbusy++;
            if (mem_we) nwe++;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_busy_cycles"}, nbusy, exp_done - 1);
        check({tag, "_we_cycles"}, nwe, l);
        mem_compare(tag);
    endtask
    initial begin
        logic [DW-1:0] keep;
        int nd, nw;
        reset_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = DW'($urandom);
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        poke(12'h000, 8'h11); poke(12'h001, 8'h22); poke(12'h002, 8'h33);
        run_job("t1", 1'b0, 12'h000, 12'h100, 13'd3, 8'h00, 0);
        check("t1_b0", ram[12'h100], 8'h11);
        check("t1_b1", ram[12'h101], 8'h22);
        check("t1_b2", ram[12'h102], 8'h33);
        keep = ref_mem[12'h002];
        run_job("t2", 1'b1, 12'h000, 12'hFFE, 13'd4, 8'hAA, 0);
        check("t2_wrap_ffe", ram[12'hFFE], 8'hAA);
        check("t2_wrap_001", ram[12'h001], 8'hAA);
        check("t2_untouched", ram[12'h002], keep);
        run_job("t3", 1'b0, 12'h123, 12'h456, 13'd0, 8'h00, 0);
        run_job("t4", 1'b0, 12'h040, 12'h080, 13'd3, 8'h00, 3);
        poke(12'h010, 8'd1); poke(12'h011, 8'd2); poke(12'h012, 8'd3); poke(12'h013, 8'd4);
        run_job("t5", 1'b0, 12'h010, 12'h011, 13'd3, 8'h00, 0);
        check("t5_b3", ram[12'h013], 8'd1);
        run_job("same", 1'b0, 12'h321, 12'h321, 13'd6, 8'h00, 0);
        // Abort a 4-byte COPY in its third cycle: only the first byte lands
        ref_mem[12'h300] = ref_mem[12'h200];
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_addr = 12'h200; dst_addr = 12'h300; length = 13'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("t6_we_after_rst", mem_we, 0);
        check("t6_busy_after_rst", busy, 0);
        check("t6_addr_after_rst", mem_addr, 0);
        nd = 0; nw = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) nd++;
            if (mem_we) nw++;
            @(posedge clk);
            #1;
        end
        check("t6_no_done", nd, 0);
        check("t6_no_we", nw, 0);
        mem_compare("t6");
        run_job("t6_next", 1'b0, 12'h200, 12'h300, 13'd4, 8'h00, 0);
        run_job("full_fill", 1'b1, 12'h000, 12'h123, 13'd4096, 8'h5A, 0);
        for (int i = 0; i < N; i++) poke(AW'(i), DW'($urandom));
        run_job("full_copy", 1'b0, 12'hF00, 12'h010, 13'd4096, 8'h00, 0);
        for (int j = 0; j < 20; j++)
            run_job($sformatf("rnd%0d", j), 1'($urandom), AW'($urandom), AW'($urandom),
                    13'($urandom_range(0, 40)), DW'($urandom), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
